// File: rtl/lbus_arbiter.sv
// -----------------------------------------------------------------------------
// lbus_arbiter
//
// Two-port round-robin arbiter and sequencer for the single-master local bus
// in front of the 8x8-bit register map. The register map double-flop
// synchronises rd_en/wr_en and commits writes on the synchronised rising edge
// of wr_en. Each access therefore holds its enable for ACCESS_CYCLES, then
// keeps address/data stable for GAP_CYCLES with the enable low. This gives
// back-to-back writes distinct edges and keeps the address valid while the
// delayed write commits.
//
// Parameters:
//   ACCESS_CYCLES  enable-high window, legal 3..15
//   GAP_CYCLES     enable-low recovery window, legal 2..15
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/req1            request, held high until the matching ack
//   we0/we1              1 = write, 0 = read (stable while req high)
//   addr0/addr1 [23:0]   byte address (stable while req high)
//   wdata0/wdata1 [7:0]  write data (stable while req high)
//   ack0/ack1            one-cycle completion pulse
//   req_rdata [7:0]      read data, valid with ack, held until next read
//   lbus_rd_en           read enable to register map
//   lbus_wr_en           write enable to register map
//   lbus_address [23:0]  bus address, changes only on a grant
//   lbus_wdata [7:0]     bus write data, changes only on a grant
//   lbus_rdata [7:0]     combinational read data from register map
//   state_dbg [1:0]      current FSM state (0 idle, 1 access, 2 recover)
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// them until ackN. ackN pulses for one cycle in the first recover cycle. A req
// still high when IDLE is re-entered counts as a new request. A req dropped
// early does not cancel the transaction in flight.
// -----------------------------------------------------------------------------
module lbus_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  req_rdata,
    output logic        lbus_rd_en,
    output logic        lbus_wr_en,
    output logic [23:0] lbus_address,
    output logic [7:0]  lbus_wdata,
    input  logic [7:0]  lbus_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       cur_id;
    logic       cur_we;

    // Winner selection. On a tie, the port that was not served last wins.
    logic        grant_valid;
    logic        grant_id;
    logic        grant_we;
    logic [23:0] grant_addr;
    logic [7:0]  grant_wdata;

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end
        grant_we    = grant_id ? we1    : we0;
        grant_addr  = grant_id ? addr1  : addr0;
        grant_wdata = grant_id ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            last_grant   <= 1'b1;
            cur_id       <= 1'b0;
            cur_we       <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            req_rdata    <= 8'h00;
            lbus_rd_en   <= 1'b0;
            lbus_wr_en   <= 1'b0;
            lbus_address <= 24'h000000;
            lbus_wdata   <= 8'h00;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        cur_id       <= grant_id;
                        last_grant   <= grant_id;
                        cur_we       <= grant_we;
                        lbus_address <= grant_addr;
                        lbus_wdata   <= grant_wdata;
                        lbus_wr_en   <= grant_we;
                        lbus_rd_en   <= ~grant_we;
                        cnt          <= ACC_LOAD;
                        state        <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Final enable cycle: the read path has had the whole
                        // window to settle, so capture here.
                        if (!cur_we) begin
                            req_rdata <= lbus_rdata;
                        end
                        lbus_wr_en <= 1'b0;
                        lbus_rd_en <= 1'b0;
                        ack0       <= ~cur_id;
                        ack1       <= cur_id;
                        cnt        <= GAP_LOAD;
                        state      <= S_RECOVER;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RECOVER: begin
                    // Address/data stay put: the synchronised write edge
                    // lands in this window.
                    if (cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_lbus_arbiter.sv
module tb_lbus_arbiter;

  localparam int ACC = 4;
  localparam int GAP = 2;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [23:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  req_rdata;
  logic        lbus_rd_en, lbus_wr_en;
  logic [23:0] lbus_address;
  logic [7:0]  lbus_wdata;
  logic [7:0]  lbus_rdata;
  logic [1:0]  state_dbg;

  lbus_arbiter #(.ACCESS_CYCLES(ACC), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .req_rdata(req_rdata),
    .lbus_rd_en(lbus_rd_en), .lbus_wr_en(lbus_wr_en),
    .lbus_address(lbus_address), .lbus_wdata(lbus_wdata),
    .lbus_rdata(lbus_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register map model: 8x8 regs, two-flop synchronised write enable,
  // commit on synchronised rising edge, out-of-range reads return 0
  logic [7:0] regs [8];
  logic       wr_s1, wr_s2, wr_s3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      wr_s1 <= 1'b0; wr_s2 <= 1'b0; wr_s3 <= 1'b0;
    end else begin
      wr_s1 <= lbus_wr_en; wr_s2 <= wr_s1; wr_s3 <= wr_s2;
      if (wr_s2 && !wr_s3 && lbus_address < 24'd8)
        regs[lbus_address[2:0]] <= lbus_wdata;
    end
  end

  assign lbus_rdata = (lbus_address < 24'd8) ? regs[lbus_address[2:0]] : 8'h00;

  // scoreboard state
  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [7:0] shadow [8];
  logic [7:0] last_rd = 8'h00;

  // event logs (cycle stamps) filled by the monitor
  int         cyc = 0;
  logic       en_prev = 1'b0;
  int         rise_q[$];
  logic       rise_wr_q[$];
  int         fall_q[$];
  int         ack_cyc_q[$];
  logic       ack_id_q[$];

  always @(negedge clk) begin
    logic       en_now;
    logic [8:0] e;
    cyc++;
    if (!rst_n) begin
      en_prev = 1'b0;
    end else begin
      en_now = lbus_rd_en | lbus_wr_en;
      if (en_now && !en_prev) begin
        rise_q.push_back(cyc);
        rise_wr_q.push_back(lbus_wr_en);
      end
      if (!en_now && en_prev) fall_q.push_back(cyc);
      en_prev = en_now;
      if (ack0 || ack1) begin
        ack_cyc_q.push_back(cyc);
        ack_id_q.push_back(ack1);
        n_vec++;
        if (ack0 && ack1) begin
          n_err++;
          $display("FAIL sb_both_acks: ack0=%0b ack1=%0b, required one-hot", ack0, ack1);
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_ack: ack1=%0b rdata=%02h, required no ack", ack1, req_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({ack1, req_rdata} !== e)
            begin
              n_err++;
              $display("FAIL sb_ack: got id=%0b rdata=%02h, required id=%0b rdata=%02h",
                       ack1, req_rdata, e[8], e[7:0]);
            end
        end
      end
    end
  end

  // driver tasks
  task automatic clear_logs();
    rise_q.delete(); rise_wr_q.delete(); fall_q.delete();
    ack_cyc_q.delete(); ack_id_q.delete();
  endtask

  task automatic start_req(input int id, input bit we, input logic [23:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic [8:0] e;
    if (we) begin
      if (a < 24'd8) shadow[a[2:0]] = d;
      rd = last_rd;
    end else begin
      rd = (a < 24'd8) ? shadow[a[2:0]] : 8'h00;
      last_rd = rd;
    end
    e = {(id == 1), rd};
    exp_q.push_back(e);
    if (id == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else         begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
  endtask

  task automatic wait_acks(input int n, input bit drop);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 200) begin
      @(posedge clk); #1;
      budget++;
      if (ack0) begin got++; if (drop) req0 = 1'b0; end
      if (ack1) begin got++; if (drop) req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    if (got < n) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got %0d acks, required %0d", got, n);
    end
  endtask

  task automatic settle();
    repeat (GAP + 2) @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int id, input bit we, input logic [23:0] a, input logic [7:0] d);
    start_req(id, we, a, d);
    wait_acks(1, 1'b1);
    settle();
  endtask

  // tests
  task automatic test_reset();
    n_vec++;
    if ({ack0, ack1, lbus_rd_en, lbus_wr_en, lbus_address, lbus_wdata, req_rdata} !== 44'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %011h, required 0",
               {ack0, ack1, lbus_rd_en, lbus_wr_en, lbus_address, lbus_wdata, req_rdata});
    end
    n_vec++;
    if (state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required 0", state_dbg);
    end
  endtask

  task automatic test_simultaneous();
    clear_logs();
    start_req(0, 1'b1, 24'h000001, 8'h11);
    start_req(1, 1'b1, 24'h000002, 8'h22);
    wait_acks(2, 1'b1);
    settle();
    n_vec++;
    if (ack_id_q.size() != 2 || ack_id_q[0] !== 1'b0 || ack_id_q[1] !== 1'b1) begin
      n_err++;
      $display("FAIL tie_order: got %0d acks first_id=%0b, required 2 acks order 0,1",
               ack_id_q.size(), (ack_id_q.size() > 0) ? ack_id_q[0] : 1'bx);
    end
    n_vec++;
    if (rise_q.size() != 2 || (rise_q[1] - rise_q[0]) != ACC + GAP + 1) begin
      n_err++;
      $display("FAIL tie_spacing: got %0d grants spacing %0d, required 2 spacing %0d",
               rise_q.size(), (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1, ACC + GAP + 1);
    end
    do_txn(0, 1'b0, 24'h000001, 8'h00);
    do_txn(1, 1'b0, 24'h000002, 8'h00);
  endtask

  task automatic test_continuous();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, shadow[1]});
      exp_q.push_back({1'b1, shadow[2]});
    end
    last_rd = shadow[2];
    we0 = 1'b0; addr0 = 24'h000001; req0 = 1'b1;
    we1 = 1'b0; addr1 = 24'h000002; req1 = 1'b1;
    wait_acks(6, 1'b0);
    settle();
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (ack_id_q.size() != 6 || ack_id_q[i] !== i[0]) begin
        n_err++;
        $display("FAIL cont_order_%0d: got id=%0b (of %0d), required %0b",
                 i, (i < ack_id_q.size()) ? ack_id_q[i] : 1'bx, ack_id_q.size(), i[0]);
      end
    end
    for (int i = 1; i < 6; i++) begin
      n_vec++;
      if (ack_cyc_q.size() != 6 || rise_q.size() != 6 || fall_q.size() != 6 ||
          (ack_cyc_q[i] - ack_cyc_q[i-1]) != ACC + GAP + 1 || rise_q[i] <= fall_q[i-1]) begin
        n_err++;
        $display("FAIL cont_spacing_%0d: got acks=%0d rises=%0d falls=%0d, required 6 each, spacing %0d, no overlap",
                 i, ack_cyc_q.size(), rise_q.size(), fall_q.size(), ACC + GAP + 1);
      end
    end
  endtask

  task automatic test_write_read();
    clear_logs();
    do_txn(0, 1'b1, 24'h000003, 8'hA5);
    n_vec++;
    if (rise_q.size() != 1 || fall_q.size() != 1 || rise_wr_q[0] !== 1'b1 || (fall_q[0] - rise_q[0]) != ACC) begin
      n_err++;
      $display("FAIL wr_en_width: got %0d rises width %0d, required 1 write width %0d",
               rise_q.size(), (fall_q.size() > 0 && rise_q.size() > 0) ? fall_q[0] - rise_q[0] : -1, ACC);
    end
    n_vec++;
    // rise is grant+1, ack is grant+ACC+1
    if (ack_cyc_q.size() != 1 || rise_q.size() != 1 || (ack_cyc_q[0] - rise_q[0]) != ACC) begin
      n_err++;
      $display("FAIL ack_latency: got %0d acks, required 1 ack %0d cycles after grant", ack_cyc_q.size(), ACC + 1);
    end
    do_txn(0, 1'b0, 24'h000003, 8'h00);
    n_vec++;
    if (ack_id_q.size() != 2 || ack_id_q[0] !== 1'b0 || ack_id_q[1] !== 1'b0) begin
      n_err++;
      $display("FAIL no_ack1: got %0d acks, required 2 acks on port 0 only", ack_id_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    start_req(1, 1'b1, 24'h000000, 8'h01);
    wait_acks(1, 1'b1);
    start_req(1, 1'b1, 24'h000000, 8'h02);
    wait_acks(1, 1'b1);
    settle();
    n_vec++;
    if (rise_q.size() != 2 || fall_q.size() != 2 || (rise_q[1] - fall_q[0]) < GAP + 1) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d rises low gap %0d, required 2 rises gap >= %0d",
               rise_q.size(), (rise_q.size() == 2 && fall_q.size() > 0) ? rise_q[1] - fall_q[0] : -1, GAP + 1);
    end
    do_txn(0, 1'b0, 24'h000000, 8'h00);
  endtask

  task automatic test_out_of_range();
    clear_logs();
    do_txn(1, 1'b0, 24'h000100, 8'h00);
    n_vec++;
    if (ack_cyc_q.size() != 1 || rise_q.size() != 1 || (ack_cyc_q[0] - rise_q[0]) != ACC) begin
      n_err++;
      $display("FAIL oor_timing: got %0d acks, required 1 ack %0d cycles after grant", ack_cyc_q.size(), ACC + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int          id;
      logic [23:0] a;
      logic [7:0]  d;
      id = $urandom_range(0, 1);
      a  = 24'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      do_txn(id, 1'b1, a, d);
      do_txn(1 - id, 1'b0, a, 8'h00);
    end
  endtask

  task automatic test_reset_mid_access();
    int budget = 0;
    int acks_before;
    we0 = 1'b1; addr0 = 24'h000003; wdata0 = 8'h5A; req0 = 1'b1;
    while (!lbus_wr_en && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    n_vec++;
    if (!lbus_wr_en) begin
      n_err++;
      $display("FAIL rst_mid_start: got wr_en=%0b, required 1", lbus_wr_en);
    end
    acks_before = ack_cyc_q.size();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ack0, ack1, lbus_rd_en, lbus_wr_en, lbus_address, lbus_wdata, req_rdata} !== 44'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %011h, required 0",
               {ack0, ack1, lbus_rd_en, lbus_wr_en, lbus_address, lbus_wdata, req_rdata});
    end
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    last_rd = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (ack_cyc_q.size() != acks_before) begin
      n_err++;
      $display("FAIL rst_mid_no_ack: got %0d acks, required %0d", ack_cyc_q.size(), acks_before);
    end
    clear_logs();
    start_req(0, 1'b1, 24'h000004, 8'h33);
    start_req(1, 1'b1, 24'h000005, 8'h44);
    wait_acks(2, 1'b1);
    settle();
    n_vec++;
    if (ack_id_q.size() != 2 || ack_id_q[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_tie: got %0d acks first_id=%0b, required first id 0",
               ack_id_q.size(), (ack_id_q.size() > 0) ? ack_id_q[0] : 1'bx);
    end
    do_txn(1, 1'b0, 24'h000003, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_simultaneous();
    test_continuous();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_access();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
